kc705_rst_sequencer: RTL and testbench

- Takes the combined lock/ready indication (`mmcms_locked`) from the KC705 PCIe board-level glue and generates the staged, synchronous, active-low user resets for the 125 MHz PCIe fabric domain.
- Release only happens after lock has been stable for a qualified time. Resets are released in a fixed order: core → PCIe user logic → DDR user logic.
- Loss of lock or a soft request re-asserts all resets immediately.
- Also exports a compact status vector intended for the board LEDs.

---
 rtl/kc705_rst_sequencer.sv | 167 ++++++++++++++++
 tb/tb_kc705_rst_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kc705_rst_sequencer.sv
// rtl/kc705_rst_sequencer.sv - staged active-low reset sequencer for the KC705 PCIe 125 MHz domain
//
// Ports:
//   pcie_clk_125MHz  sole clock
//   sys_rst_n        synchronous active-low reset
//   mmcms_locked     asynchronous lock/ready level, double-flop synchronized here
//   soft_rst_req     single-cycle request for a full re-sequence
//   core_rst_n       stage-0 reset (active-low)
//   pcie_user_rst_n  stage-1 reset (active-low)
//   ddr_user_rst_n   stage-2 reset (active-low)
//   seq_done         high while in RUN
//   seq_state        current FSM state code
//   lock_loss_cnt    saturating count of lock losses after qualification

module kc705_rst_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 64,
    parameter int CNT_W              = 16
) (
    input  logic       pcie_clk_125MHz,
    input  logic       sys_rst_n,
    input  logic       mmcms_locked,
    input  logic       soft_rst_req,
    output logic       core_rst_n,
    output logic       pcie_user_rst_n,
    output logic       ddr_user_rst_n,
    output logic       seq_done,
    output logic [2:0] seq_state,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        QUALIFY   = 3'd1,
        REL0      = 3'd2,
        REL1      = 3'd3,
        REL2      = 3'd4,
        RUN       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] QUAL_END = CNT_W'(LOCK_STABLE_CYCLES);
    // The gap counter starts at 0 on stage entry, so STAGE_GAP edges have
    // elapsed when it reads STAGE_GAP-1.
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(STAGE_GAP - 1);

    state_t           state, state_nxt;
    logic             lock_meta, lock_s;
    logic [CNT_W-1:0] qual_cnt, qual_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_nxt;
    logic             core_nxt, pcie_nxt, ddr_nxt, done_nxt;
    logic [7:0]       loss_nxt;
    logic             abort;

    assign abort     = !lock_s || soft_rst_req;
    assign seq_state = state;

    always_ff @(posedge pcie_clk_125MHz) begin
        if (!sys_rst_n) begin
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            state           <= WAIT_LOCK;
            qual_cnt        <= '0;
            gap_cnt         <= '0;
            core_rst_n      <= 1'b0;
            pcie_user_rst_n <= 1'b0;
            ddr_user_rst_n  <= 1'b0;
            seq_done        <= 1'b0;
            lock_loss_cnt   <= 8'd0;
        end else begin
            lock_meta       <= mmcms_locked;
            lock_s          <= lock_meta;
            state           <= state_nxt;
            qual_cnt        <= qual_nxt;
            gap_cnt         <= gap_nxt;
            core_rst_n      <= core_nxt;
            pcie_user_rst_n <= pcie_nxt;
            ddr_user_rst_n  <= ddr_nxt;
            seq_done        <= done_nxt;
            lock_loss_cnt   <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        qual_nxt  = qual_cnt;
        gap_nxt   = gap_cnt;
        core_nxt  = core_rst_n;
        pcie_nxt  = pcie_user_rst_n;
        ddr_nxt   = ddr_user_rst_n;
        done_nxt  = seq_done;
        loss_nxt  = lock_loss_cnt;

        case (state)
            WAIT_LOCK: begin
                core_nxt = 1'b0;
                pcie_nxt = 1'b0;
                ddr_nxt  = 1'b0;
                done_nxt = 1'b0;
                qual_nxt = '0;
                gap_nxt  = '0;
                if (lock_s && !soft_rst_req) begin
                    state_nxt = QUALIFY;
                    qual_nxt  = CNT_W'(1);
                end
            end
            QUALIFY: begin
                if (abort) begin
                    // A dropout before qualification is not a lock loss.
                    state_nxt = WAIT_LOCK;
                    qual_nxt  = '0;
                end else if (qual_cnt == QUAL_END) begin
                    state_nxt = REL0;
                    core_nxt  = 1'b1;
                    qual_nxt  = '0;
                    gap_nxt   = '0;
                end else begin
                    qual_nxt = qual_cnt + CNT_W'(1);
                end
            end
            REL0, REL1, REL2, RUN: begin
                if (abort) begin
                    state_nxt = WAIT_LOCK;
                    core_nxt  = 1'b0;
                    pcie_nxt  = 1'b0;
                    ddr_nxt   = 1'b0;
                    done_nxt  = 1'b0;
                    qual_nxt  = '0;
                    gap_nxt   = '0;
                    if (!lock_s && lock_loss_cnt != 8'hFF) begin
                        loss_nxt = lock_loss_cnt + 8'd1;
                    end
                end else if (state != RUN) begin
                    if (gap_cnt == GAP_END) begin
                        gap_nxt = '0;
                        case (state)
                            REL0: begin
                                state_nxt = REL1;
                                pcie_nxt  = 1'b1;
                            end
                            REL1: begin
                                state_nxt = REL2;
                                ddr_nxt   = 1'b1;
                            end
                            default: begin
                                state_nxt = RUN;
                                done_nxt  = 1'b1;
                            end
                        endcase
                    end else begin
                        gap_nxt = gap_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                // Codes 6 and 7 are unreachable; fall back to a safe reset state.
                state_nxt = WAIT_LOCK;
                core_nxt  = 1'b0;
                pcie_nxt  = 1'b0;
                ddr_nxt   = 1'b0;
                done_nxt  = 1'b0;
                qual_nxt  = '0;
                gap_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_kc705_rst_sequencer.sv
// tb/tb_kc705_rst_sequencer.sv - directed self-checking bench for kc705_rst_sequencer

module tb_kc705_rst_sequencer;

    localparam int L = 8;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       mmcms_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_loss = 0;

    kc705_rst_sequencer #(.LOCK_STABLE_CYCLES(L), .STAGE_GAP(G), .CNT_W(16)) dut (
        .pcie_clk_125MHz (clk),
        .sys_rst_n       (sys_rst_n),
        .mmcms_locked    (mmcms_locked),
        .soft_rst_req    (soft_rst_req),
        .core_rst_n      (core_rst_n),
        .pcie_user_rst_n (pcie_user_rst_n),
        .ddr_user_rst_n  (ddr_user_rst_n),
        .seq_done        (seq_done),
        .seq_state       (seq_state),
        .lock_loss_cnt   (lock_loss_cnt)
    );

    always #4 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done, seq_state} !== 7'd0) begin
            errors++;
            $display("FAIL %s outputs got %b state %0d exp all 0 state 0", name,
                     {core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done}, seq_state);
        end
    endtask

    task automatic do_reset;
        sys_rst_n    = 1'b0;
        mmcms_locked = 1'b0;
        soft_rst_req = 1'b0;
        repeat (5) tick;
        exp_loss  = 0;
        sys_rst_n = 1'b1;
    endtask

    // Caller has just driven mmcms_locked high; edge n=0 is the first edge sampling it.
    task automatic check_sequence(input int last_n, input bit chk_early_state);
        logic [3:0] exp_out;
        logic [2:0] exp_state;
        for (int n = 0; n <= last_n; n++) begin
            tick;
            exp_out = {n >= L + 2, n >= L + 2 + G, n >= L + 2 + 2 * G, n >= L + 2 + 3 * G};
            if (n < 2)                     exp_state = 3'd0;
            else if (n < L + 2)            exp_state = 3'd1;
            else if (n < L + 2 + G)        exp_state = 3'd2;
            else if (n < L + 2 + 2 * G)    exp_state = 3'd3;
            else if (n < L + 2 + 3 * G)    exp_state = 3'd4;
            else                           exp_state = 3'd5;
            checks++;
            if ({core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done} !== exp_out) begin
                errors++;
                $display("FAIL seq_outputs n=%0d got %b exp %b", n,
                         {core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done}, exp_out);
            end
            if (chk_early_state || n >= 2) begin
                checks++;
                if (seq_state !== exp_state) begin
                    errors++;
                    $display("FAIL seq_state n=%0d got %0d exp %0d", n, seq_state, exp_state);
                end
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'(exp_loss)) begin
            errors++;
            $display("FAIL seq_loss_cnt got %0d exp %0d", lock_loss_cnt, exp_loss);
        end
    endtask

    task automatic test_reset;
        sys_rst_n    = 1'b0;
        mmcms_locked = 1'b1;
        repeat (5) begin
            tick;
            check_all_zero("reset_hold");
            checks++;
            if (lock_loss_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_loss_cnt got %0d exp 0", lock_loss_cnt);
            end
        end
        mmcms_locked = 1'b0;
        tick;
        check_all_zero("reset_hold_last");
        sys_rst_n = 1'b1;
        exp_loss  = 0;
        repeat (3) tick;
        check_all_zero("reset_idle");
    endtask

    task automatic test_power_up;
        mmcms_locked = 1'b1;
        check_sequence(L + 2 + 3 * G + 2, 1'b1);
    endtask

    task automatic test_lock_loss_run;
        mmcms_locked = 1'b0;
        tick;
        tick;
        checks++;
        if (seq_done !== 1'b1 || seq_state !== 3'd5) begin
            errors++;
            $display("FAIL loss_still_run got done %b state %0d exp 1 5", seq_done, seq_state);
        end
        tick;
        exp_loss = 1;
        check_all_zero("loss_abort");
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL loss_cnt got %0d exp 1", lock_loss_cnt);
        end
        mmcms_locked = 1'b1;
        check_sequence(L + 2 + 3 * G + 2, 1'b1);
    endtask

    task automatic test_soft_rel1;
        mmcms_locked = 1'b0;
        repeat (3) tick;
        exp_loss = 2;
        check_all_zero("soft_pre_abort");
        mmcms_locked = 1'b1;
        check_sequence(L + 2 + G + 1, 1'b1);
        soft_rst_req = 1'b1;
        tick;
        soft_rst_req = 1'b0;
        check_all_zero("soft_abort");
        checks++;
        if (lock_loss_cnt !== 8'd2) begin
            errors++;
            $display("FAIL soft_loss_cnt got %0d exp 2", lock_loss_cnt);
        end
        tick;
        checks++;
        if (seq_state !== 3'd1 || core_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL soft_requalify got state %0d core %b exp 1 0", seq_state, core_rst_n);
        end
    endtask

    task automatic test_qualify_glitch;
        do_reset;
        repeat (2) tick;
        mmcms_locked = 1'b1;
        repeat (5) begin
            tick;
            check_all_zero_resets("glitch_high");
        end
        mmcms_locked = 1'b0;
        tick;
        mmcms_locked = 1'b1;
        check_sequence(L + 2 + 3 * G + 2, 1'b0);
    endtask

    task automatic check_all_zero_resets(input string name);
        checks++;
        if ({core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done} !== 4'd0) begin
            errors++;
            $display("FAIL %s got %b exp 0000", name,
                     {core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done});
        end
    endtask

    task automatic test_simultaneous;
        mmcms_locked = 1'b0;
        tick;
        tick;
        soft_rst_req = 1'b1;
        tick;
        soft_rst_req = 1'b0;
        exp_loss = 1;
        check_all_zero("simul_abort");
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL simul_loss_cnt got %0d exp 1", lock_loss_cnt);
        end
    endtask

    task automatic test_saturation;
        int waited;
        for (int i = 0; i < 260; i++) begin
            mmcms_locked = 1'b1;
            waited = 0;
            while (seq_done !== 1'b1 && waited < 60) begin
                tick;
                waited++;
            end
            if (seq_done !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL sat_timeout iter %0d got done %b exp 1", i, seq_done);
                break;
            end
            mmcms_locked = 1'b0;
            repeat (3) tick;
            if (exp_loss < 255) exp_loss++;
            checks++;
            if (lock_loss_cnt !== 8'(exp_loss)) begin
                errors++;
                $display("FAIL sat_cnt iter %0d got %0d exp %0d", i, lock_loss_cnt, exp_loss);
            end
        end
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_final got %0d exp 255", lock_loss_cnt);
        end
    endtask

    task automatic test_reset_override;
        mmcms_locked = 1'b1;
        check_sequence(L + 2 + 2 * G + 1, 1'b1);
        sys_rst_n = 1'b0;
        tick;
        exp_loss = 0;
        check_all_zero("override");
        checks++;
        if (lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL override_loss_cnt got %0d exp 0", lock_loss_cnt);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_random_order;
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) mmcms_locked = ~mmcms_locked;
            soft_rst_req = ($urandom_range(0, 99) == 0);
            tick;
            checks++;
            if ((pcie_user_rst_n && !core_rst_n) || (ddr_user_rst_n && !pcie_user_rst_n) ||
                (seq_done && !ddr_user_rst_n) || seq_state > 3'd5) begin
                errors++;
                $display("FAIL order cycle %0d got %b state %0d exp monotonic", c,
                         {core_rst_n, pcie_user_rst_n, ddr_user_rst_n, seq_done}, seq_state);
            end
        end
        soft_rst_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_lock_loss_run;
        test_soft_rel1;
        test_qualify_glitch;
        test_simultaneous;
        test_saturation;
        test_reset_override;
        test_random_order;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
